// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush/freeze control for a 5-stage MIPS pipeline
//   Inputs : hazard_detected (load-use), branch_taken_EX, jump_ID,
//            dmem_req / dmem_ready (data-memory handshake)
//   Outputs: pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
//            mem_timeout (sticky), stall_cnt / flush_cnt / memwait_cnt (saturating)
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_detected,
  input  logic             branch_taken_EX,
  input  logic             jump_ID,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);
  localparam int WW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WW-1:0] WLAST = WW'(MEM_TIMEOUT - 1);
  typedef enum logic [1:0] {RUN, WAIT, ERROR} state_e;
  state_e           state_q, state_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_q, flush_q, memwait_q;
  logic             pending, freeze, br, ld, jp;
  assign pending = dmem_req & ~dmem_ready;
  assign freeze  = (state_q == ERROR) | pending;
  // Mutually exclusive priority levels below freeze; a taken branch squashes
  // the instruction a load-use stall would have held.
  assign br = ~freeze & branch_taken_EX;
  assign ld = ~freeze & ~branch_taken_EX & hazard_detected;
  assign jp = ~freeze & ~branch_taken_EX & ~hazard_detected & jump_ID;
  // rst_n gating forces the reset control values while reset is held.
  assign pc_write     = rst_n & ~freeze & ~ld;
  assign if_id_write  = rst_n & ~freeze & ~ld;
  assign if_id_flush  = rst_n & (br | jp);
  assign id_ex_bubble = ~rst_n | br | ld;
  assign pipe_hold    = rst_n & freeze;
  assign mem_timeout  = timeout_q;
  assign stall_cnt    = stall_q;
  assign flush_cnt    = flush_q;
  assign memwait_cnt  = memwait_q;
  // Wait counter is held at zero in RUN so it starts cleared on entry to WAIT.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      RUN: begin
        state_d = pending ? WAIT : RUN;
        wcnt_d  = '0;
      end
      WAIT: begin
        state_d = !pending ? RUN : (wcnt_q == WLAST ? ERROR : WAIT);
        wcnt_d  = wcnt_q + 1'b1;
      end
      default: state_d = ERROR;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
      memwait_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_q | (state_d == ERROR);
      stall_q   <= stall_q + CNT_W'(ld & ~&stall_q);
      flush_q   <= flush_q + CNT_W'((br | jp) & ~&flush_q);
      memwait_q <= memwait_q + CNT_W'(pending & ~&memwait_q);
    end
  end
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed and randomized checks of pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;
  localparam int MT  = 4;
  localparam int CW  = 4;
  localparam int SAT = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hazard_detected = 1'b0, branch_taken_EX = 1'b0, jump_ID = 1'b0;
  logic dmem_req = 1'b0, dmem_ready = 1'b0;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt, memwait_cnt;
  int errors = 0;
  int checks = 0;
  int m_stall, m_flush, m_memw, m_consec;
  bit m_err;
  logic [4:0] ctrl;

  pipeline_stall_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .hazard_detected(hazard_detected), .branch_taken_EX(branch_taken_EX),
    .jump_ID(jump_ID), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_hold(pipe_hold), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
  );

  always #5 clk = ~clk;
  assign ctrl = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold};

  // Reference model: error after more than MT consecutive pending cycles.
  function automatic logic [4:0] exp_ctrl();
    if (!rst_n) return 5'b00010;
    if (m_err || (dmem_req && !dmem_ready)) return 5'b00001;
    if (branch_taken_EX) return 5'b11110;
    if (hazard_detected) return 5'b00010;
    if (jump_ID) return 5'b11100;
    return 5'b11000;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < SAT) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_stall = 0; m_flush = 0; m_memw = 0; m_consec = 0; m_err = 0;
  endtask

  task automatic model_edge();
    bit pend, fr;
    pend = dmem_req && !dmem_ready;
    fr = m_err || pend;
    if (!fr && branch_taken_EX) m_flush = sat_inc(m_flush);
    else if (!fr && hazard_detected) m_stall = sat_inc(m_stall);
    else if (!fr && jump_ID) m_flush = sat_inc(m_flush);
    if (pend) m_memw = sat_inc(m_memw);
    m_consec = pend ? m_consec + 1 : 0;
    if (m_consec > MT) m_err = 1;
  endtask

  task automatic set_in(input logic h, b, j, q, r);
    @(negedge clk);
    hazard_detected = h; branch_taken_EX = b; jump_ID = j; dmem_req = q; dmem_ready = r;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    hazard_detected = 0; branch_taken_EX = 0; jump_ID = 0; dmem_req = 0; dmem_ready = 0;
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ctrl !== 5'b00010) begin errors++; $display("FAIL reset_ctrl got=%b exp=00010", ctrl); end
    checks++;
    if ({stall_cnt, flush_cnt, memwait_cnt, mem_timeout} !== '0)
      begin errors++; $display("FAIL reset_regs got=%h/%h/%h/%b exp=0", stall_cnt, flush_cnt, memwait_cnt, mem_timeout); end
    #1 rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0);
    checks++;
    if (ctrl !== 5'b11000) begin errors++; $display("FAIL idle_ctrl got=%b exp=11000", ctrl); end
    tick();
    checks++;
    if ({stall_cnt, flush_cnt, memwait_cnt, mem_timeout} !== '0)
      begin errors++; $display("FAIL idle_regs got=%h/%h/%h/%b exp=0", stall_cnt, flush_cnt, memwait_cnt, mem_timeout); end
  endtask

  task automatic test_hazard();
    do_reset();
    set_in(1, 0, 0, 0, 0);
    checks++;
    if (ctrl !== 5'b00010) begin errors++; $display("FAIL hazard_ctrl got=%b exp=00010", ctrl); end
    tick();
    checks++;
    if (stall_cnt !== 4'd1) begin errors++; $display("FAIL hazard_cnt got=%0d exp=1", stall_cnt); end
    set_in(0, 0, 0, 0, 0);
    checks++;
    if (ctrl !== 5'b11000) begin errors++; $display("FAIL hazard_release got=%b exp=11000", ctrl); end
    tick();
    checks++;
    if (stall_cnt !== 4'd1) begin errors++; $display("FAIL hazard_cnt_hold got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_branch_over_hazard();
    do_reset();
    set_in(1, 1, 0, 0, 0);
    checks++;
    if (ctrl !== 5'b11110) begin errors++; $display("FAIL br_hz_ctrl got=%b exp=11110", ctrl); end
    tick();
    checks++;
    if ({stall_cnt, flush_cnt} !== {4'd0, 4'd1})
      begin errors++; $display("FAIL br_hz_cnt got=%0d/%0d exp=0/1", stall_cnt, flush_cnt); end
    set_in(0, 0, 1, 0, 0);
    checks++;
    if (ctrl !== 5'b11100) begin errors++; $display("FAIL jump_ctrl got=%b exp=11100", ctrl); end
    tick();
    checks++;
    if (flush_cnt !== 4'd2) begin errors++; $display("FAIL jump_cnt got=%0d exp=2", flush_cnt); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 0, 1, 0);
      checks++;
      if (ctrl !== 5'b00001) begin errors++; $display("FAIL memwait_freeze[%0d] got=%b exp=00001", i, ctrl); end
      tick();
    end
    set_in(0, 1, 0, 1, 1);
    checks++;
    if (ctrl !== 5'b11110) begin errors++; $display("FAIL memwait_release got=%b exp=11110", ctrl); end
    tick();
    checks++;
    if ({memwait_cnt, flush_cnt, mem_timeout} !== {4'd3, 4'd1, 1'b0})
      begin errors++; $display("FAIL memwait_cnt got=%0d/%0d/%b exp=3/1/0", memwait_cnt, flush_cnt, mem_timeout); end
    set_in(0, 0, 0, 0, 0);
    checks++;
    if (ctrl !== 5'b11000) begin errors++; $display("FAIL memwait_run got=%b exp=11000", ctrl); end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i <= MT; i++) begin
      set_in(0, 0, 0, 1, 0);
      tick();
      checks++;
      if (mem_timeout !== (i == MT)) begin errors++; $display("FAIL timeout_edge[%0d] got=%b exp=%b", i, mem_timeout, i == MT); end
    end
    set_in(0, 0, 0, 1, 1);
    checks++;
    if (ctrl !== 5'b00001) begin errors++; $display("FAIL timeout_freeze got=%b exp=00001", ctrl); end
    tick();
    set_in(0, 1, 0, 0, 0);
    checks++;
    if (ctrl !== 5'b00001 || mem_timeout !== 1'b1)
      begin errors++; $display("FAIL timeout_sticky got=%b/%b exp=00001/1", ctrl, mem_timeout); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ctrl !== 5'b00010) begin errors++; $display("FAIL async_rst_ctrl got=%b exp=00010", ctrl); end
    checks++;
    if ({stall_cnt, flush_cnt, memwait_cnt, mem_timeout} !== '0)
      begin errors++; $display("FAIL async_rst_regs got=%h/%h/%h/%b exp=0", stall_cnt, flush_cnt, memwait_cnt, mem_timeout); end
    #1 rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0);
    checks++;
    if (ctrl !== 5'b11000) begin errors++; $display("FAIL async_rst_run got=%b exp=11000", ctrl); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_in(1, 0, 0, 0, 0);
      tick();
      checks++;
      if (stall_cnt !== 4'((i + 1 > SAT) ? SAT : i + 1))
        begin errors++; $display("FAIL stall_sat[%0d] got=%0d exp=%0d", i, stall_cnt, (i + 1 > SAT) ? SAT : i + 1); end
    end
  endtask

  task automatic test_random();
    logic [4:0] e;
    do_reset();
    for (int i = 0; i < 480; i++) begin
      if (i % 80 == 79) do_reset();
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 9) < (((i / 80) % 2) ? 3 : 8));
      e = exp_ctrl();
      checks++;
      if (ctrl !== e) begin errors++; $display("FAIL rand_ctrl[%0d] got=%b exp=%b", i, ctrl, e); end
      tick();
      checks++;
      if ({stall_cnt, flush_cnt, memwait_cnt, mem_timeout} !== {4'(m_stall), 4'(m_flush), 4'(m_memw), m_err})
        begin errors++; $display("FAIL rand_regs[%0d] got=%0d/%0d/%0d/%b exp=%0d/%0d/%0d/%b", i,
          stall_cnt, flush_cnt, memwait_cnt, mem_timeout, m_stall, m_flush, m_memw, m_err); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_hazard();
    test_branch_over_hazard();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
